// File: rtl/mem_req_ctrl_pkg.sv
// Shared encodings and helpers for the memory request controller and its
// lane-alignment datapath.
package mem_req_ctrl_pkg;

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_LAST,
        ST_RESP
    } state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size_e'(size))
            SZ_BYTE:  return 8'h01;
            SZ_HALF:  return 8'h03;
            SZ_WORD:  return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

    // An access splits when its last byte falls into the next 8-byte word.
    function automatic logic is_split(input logic [2:0] off, input logic [1:0] size);
        logic [3:0] nbytes;
        nbytes = 4'd1 << size;
        return ({1'b0, off} + nbytes) > 4'd8;
    endfunction

endpackage

// File: rtl/mem_req_ctrl_align.sv
// Combinational lane alignment: write strobes, write-data shift across two
// words, and load-data extraction with sign/zero extension.
module mem_align
    import mem_req_ctrl_pkg::*;
(
    input  logic [1:0]          size,
    input  logic [2:0]          off,
    input  logic                zero_ext,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata_hi,
    input  logic [DATA_W-1:0]   rdata_lo,
    output logic                split,
    output logic [15:0]         strobe,
    output logic [2*DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0]   load_data
);

    logic [5:0]        shamt;
    logic [DATA_W-1:0] rd_sh;

    assign shamt    = {off, 3'b000};
    assign split    = is_split(off, size);
    assign strobe   = {8'h00, size_mask(size)} << off;
    assign wdata_sh = {{DATA_W{1'b0}}, wdata} << shamt;
    assign rd_sh    = DATA_W'({rdata_hi, rdata_lo} >> shamt);

    always_comb begin
        load_data = rd_sh;
        case (size_e'(size))
            SZ_BYTE:  load_data = zero_ext ? {56'h0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
            SZ_HALF:  load_data = zero_ext ? {48'h0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            SZ_WORD:  load_data = zero_ext ? {32'h0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default:  load_data = rd_sh;
        endcase
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Single-outstanding memory request controller: turns an arbitrarily aligned
// core access into one or two aligned 8-byte memory beats.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata,
    output logic              mem_en,
    output logic [7:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    state_e            state;
    logic              we_q;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       lo_q;

    logic              idle;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        al_size;
    logic [2:0]        al_off;
    logic [63:0]       al_wdata;
    logic [63:0]       al_hi;
    logic [63:0]       al_lo;
    logic              split;
    logic [15:0]       strobe;
    logic [127:0]      wdata_sh;
    logic [63:0]       load_data;

    // While idle the aligner sees the incoming request so beat 0 can be
    // registered on the accept edge; afterwards it sees the latched request.
    assign idle     = (state == ST_IDLE);
    assign base_q   = {addr_q[ADDR_W-1:3], 3'b000};
    assign al_size  = idle ? req_size      : size_q;
    assign al_off   = idle ? req_addr[2:0] : addr_q[2:0];
    assign al_wdata = idle ? req_wdata     : wdata_q;
    assign al_hi    = split ? mem_rdata : 64'h0;
    assign al_lo    = split ? lo_q      : mem_rdata;

    mem_align u_align (
        .size      (al_size),
        .off       (al_off),
        .zero_ext  (uns_q),
        .wdata     (al_wdata),
        .rdata_hi  (al_hi),
        .rdata_lo  (al_lo),
        .split     (split),
        .strobe    (strobe),
        .wdata_sh  (wdata_sh),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        uns_q     <= req_unsigned;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        lo_q      <= '0;
                        mem_en    <= 1'b1;
                        mem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                        mem_we    <= req_we ? strobe[7:0] : 8'h00;
                        mem_wdata <= wdata_sh[63:0];
                        req_ready <= 1'b0;
                        state     <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (split) begin
                        mem_addr  <= base_q + ADDR_W'(8);
                        mem_we    <= we_q ? strobe[15:8] : 8'h00;
                        mem_wdata <= wdata_sh[127:64];
                        state     <= ST_BEAT1;
                    end else begin
                        mem_en    <= 1'b0;
                        mem_we    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= ST_LAST;
                    end
                end
                ST_BEAT1: begin
                    lo_q      <= mem_rdata;
                    mem_en    <= 1'b0;
                    mem_we    <= '0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= ST_LAST;
                end
                ST_LAST: begin
                    if (!split) begin
                        lo_q <= mem_rdata;
                    end
                    resp_rdata <= we_q ? 64'h0 : load_data;
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
